// File: rtl/store_narrow_buffer_pkg.sv
// Shared types for the store narrowing buffer: size codes, queued entry layout
// and the alignment rule used when a store is accepted.
package store_narrow_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } st_size_e;

    localparam int WORD_W     = 32;
    localparam int BE_W       = WORD_W / 8;
    localparam int ADDR_MAX_W = 32;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [WORD_W-1:0]     wdata;
        logic [BE_W-1:0]       be;
    } st_entry_t;

    // Reserved size is never legal; halfwords need an even lane, words lane 0.
    function automatic logic st_misaligned(input st_size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrow_buffer_if.sv
// Store-side bus bundle: MEM-stage store request, data-memory write port and
// buffer status. The slave view belongs to the buffer, the master view to its environment.
interface store_narrow_buffer_if
    import store_narrow_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
);

    logic                   st_valid;
    logic                   st_ready;
    logic [1:0]             st_size;
    logic [AW-1:0]          st_addr;
    logic [WORD_W-1:0]      st_data;
    logic                   st_exc;

    logic                   mem_req;
    logic [AW-1:0]          mem_addr;
    logic [WORD_W-1:0]      mem_wdata;
    logic [BE_W-1:0]        mem_be;
    logic                   mem_ack;

    logic                   buf_empty;
    logic [$clog2(DEPTH):0] buf_count;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_be,
        output buf_empty, buf_count
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, st_exc, mem_req, mem_addr, mem_wdata, mem_be,
        input  buf_empty, buf_count
    );

endinterface

// File: rtl/store_narrow_buffer_formatter.sv
// Combinational lane formatter: replicates narrow store data across all lanes
// and builds little-endian byte enables, flagging illegal size/alignment pairs.
module store_lane_formatter
    import store_narrow_buffer_pkg::*;
(
    input  st_size_e          i_size,
    input  logic [1:0]        i_lane,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_wdata,
    output logic [BE_W-1:0]   o_be,
    output logic              o_illegal
);

    always_comb begin
        o_wdata   = i_data;
        o_be      = '0;
        o_illegal = st_misaligned(i_size, i_lane);
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_lane;
            end
            SZ_HALF: begin
                o_wdata = {2{i_data[15:0]}};
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                o_wdata = i_data;
                o_be    = 4'b1111;
            end
            default: begin
                o_wdata = i_data;
                o_be    = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: formats MEM-stage stores into word-aligned writes and
// queues them in a DEPTH-entry FIFO toward data memory; bad stores raise st_exc.
module store_narrow_buffer
    import store_narrow_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    store_narrow_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WORD_W-1:0] w_fmt_wdata;
    logic [BE_W-1:0]   w_fmt_be;
    logic              w_fmt_illegal;
    logic              w_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    st_entry_t         w_new_entry;
    st_entry_t         w_head;

    st_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_exc;

    store_lane_formatter u_fmt (
        .i_size    (st_size_e'(bus.st_size)),
        .i_lane    (bus.st_addr[1:0]),
        .i_data    (bus.st_data),
        .o_wdata   (w_fmt_wdata),
        .o_be      (w_fmt_be),
        .o_illegal (w_fmt_illegal)
    );

    // Ready depends on occupancy only, so a full buffer cannot refill on the ack cycle.
    assign w_ready  = (r_count != CW'(DEPTH));
    assign w_accept = bus.st_valid && w_ready;
    assign w_push   = w_accept && !w_fmt_illegal;
    assign w_pop    = (r_count != '0) && bus.mem_ack;

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.addr      = ADDR_MAX_W'(bus.st_addr);
        w_new_entry.addr[1:0] = 2'b00;
        w_new_entry.wdata     = w_fmt_wdata;
        w_new_entry.be        = w_fmt_be;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_exc <= w_accept && w_fmt_illegal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.st_ready  = w_ready;
    assign bus.st_exc    = r_exc;
    assign bus.mem_req   = (r_count != '0);
    assign bus.mem_addr  = AW'(w_head.addr);
    assign bus.mem_wdata = w_head.wdata;
    assign bus.mem_be    = w_head.be;
    assign bus.buf_empty = (r_count == '0);
    assign bus.buf_count = r_count;

endmodule
